// File: rtl/demux_1to4_1b_deser.sv
// demux_1to4_1b_deser
// Single-lane beat stream -> four lane registers (a..d). Beats go round-robin
// (mode=0) or to the lane chosen by sel (mode=1). A group is handed to the
// consumer once all four lanes are written, or early on flush.
//
// Handshake: a beat transfers on any rising edge where in_valid && in_ready;
// a group transfers on any rising edge where out_valid && out_ready. in_ready
// and out_valid come straight from the state, so neither depends
// combinationally on in_valid or out_ready.
module demux_1to4_1b_deser #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [1:0]   sel,
    input  logic         flush,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic [W-1:0] c_out,
    output logic [W-1:0] d_out,
    output logic [3:0]   out_mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   ptr
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_lane [4];
    logic [3:0]   r_mask;
    logic [1:0]   r_ptr;
    logic [1:0]   w_lane_sel;
    logic         w_accept;
    logic [3:0]   w_mask_post;

    // Target lane, beat acceptance, post-write mask and next state.
    always_comb begin
        w_lane_sel  = mode ? sel : r_ptr;
        w_accept    = (r_state == ST_COLLECT) && in_valid;
        w_mask_post = r_mask;
        w_state_nxt = r_state;
        if (w_accept) begin
            w_mask_post = r_mask | (4'b0001 << w_lane_sel);
        end
        case (r_state)
            ST_COLLECT: begin
                // A beat taken this cycle counts toward both the full and the flush test.
                if ((w_mask_post == 4'b1111) || (flush && (w_mask_post != 4'b0000))) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lane registers, written-lane mask and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_lane[i] <= '0;
            end
            r_mask <= 4'b0000;
            r_ptr  <= 2'd0;
        end else if (r_state == ST_COLLECT) begin
            if (w_accept) begin
                // A directed write to a filled lane overwrites it; the mask bit is already set.
                r_lane[w_lane_sel] <= in_data;
                r_mask             <= w_mask_post;
                if (!mode) begin
                    r_ptr <= r_ptr + 2'd1;
                end
            end
        end else if (out_ready) begin
            // Group handed off: start the next one from a clean slate.
            for (int i = 0; i < 4; i++) begin
                r_lane[i] <= '0;
            end
            r_mask <= 4'b0000;
            r_ptr  <= 2'd0;
        end
    end

    assign in_ready  = (r_state == ST_COLLECT);
    assign out_valid = (r_state == ST_HOLD);
    assign a_out     = r_lane[0];
    assign b_out     = r_lane[1];
    assign c_out     = r_lane[2];
    assign d_out     = r_lane[3];
    assign out_mask  = r_mask;
    assign ptr       = r_ptr;

endmodule

// File: tb/tb_demux_1to4_1b_deser.sv
// Bench for demux_1to4_1b_deser: table of groups plus hand-written corner sequences.
// Expected groups are packed as {out_mask, d, c, b, a}.
module tb_demux_1to4_1b_deser;

    localparam int W = 1;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic         flush;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [W-1:0] c_out;
    logic [W-1:0] d_out;
    logic [3:0]   out_mask;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   ptr;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        int         n;      // number of beats
        logic [3:0] m;      // mode per beat (bit k = beat k)
        logic [7:0] s;      // sel per beat (bits 2k+1:2k)
        logic [3:0] d;      // data per beat
        int         fl;     // 0 none, 1 flush with last beat, 2 flush in a separate idle cycle
        logic [7:0] grp;    // expected {mask, d, c, b, a}
        logic [1:0] ptr;    // expected pointer while the group is held
    } vec_t;

    vec_t tbl[6];

    demux_1to4_1b_deser #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .flush     (flush),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out),
        .d_out     (d_out),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ptr       (ptr)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] get_grp();
        return {out_mask, d_out, c_out, b_out, a_out};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs, let one rising edge take them, return 1 time unit later.
    task automatic drive(input logic iv, input logic m, input logic [1:0] s,
                         input logic d, input logic f, input logic ordy);
        in_valid  = iv;
        mode      = m;
        sel       = s;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Called right after the edge that should have formed a group: checks
    // latency, optionally stalls, pops the scoreboard, then hands the group off.
    task automatic finish_group(input string nm, input logic [1:0] exp_ptr, input int n_stall);
        logic [7:0] e;
        int         t;
        chk({nm, " latency out_valid"}, 32'(out_valid), 32'd1);
        t = 0;
        while (!out_valid && t < 8) begin
            idle();
            t++;
        end
        if (!out_valid) begin
            chk({nm, " timeout waiting out_valid"}, 32'(out_valid), 32'd1);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        chk({nm, " group"}, 32'(get_grp()), 32'(e));
        chk({nm, " ptr in hold"}, 32'(ptr), 32'(exp_ptr));
        chk({nm, " in_ready in hold"}, 32'(in_ready), 32'd0);
        // Stall with the consumer not ready while upstream keeps offering beats.
        for (int k = 0; k < n_stall; k++) begin
            drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
            chk({nm, " stall group stable"}, 32'(get_grp()), 32'(e));
            chk({nm, " stall out_valid"}, 32'(out_valid), 32'd1);
            chk({nm, " stall in_ready"}, 32'(in_ready), 32'd0);
            chk({nm, " stall ptr"}, 32'(ptr), 32'(exp_ptr));
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk({nm, " handoff out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " handoff in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, " handoff ptr"}, 32'(ptr), 32'd0);
        chk({nm, " handoff lanes"}, 32'(get_grp()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        for (int k = 0; k < v.n; k++) begin
            drive(1'b1, v.m[k], v.s[2*k +: 2], v.d[k], (v.fl == 1) && (k == v.n - 1), 1'b0);
        end
        exp_q.push_back(v.grp);
        if (v.fl == 2) begin
            drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        end
        finish_group(nm, v.ptr, 0);
    endtask

    initial begin
        logic [3:0] rd;

        // Reset.
        rst_n = 1'b0;
        idle();
        idle();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset ptr", 32'(ptr), 32'd0);
        chk("reset lanes", 32'(get_grp()), 32'd0);
        rst_n = 1'b1;
        idle();

        // Table of groups, each starting from an empty group with ptr=0.
        tbl[0] = '{n: 4, m: 4'b0000, s: 8'h00, d: 4'b1010, fl: 0, grp: 8'hFA, ptr: 2'd0};
        tbl[1] = '{n: 4, m: 4'b1111, s: 8'h1B, d: 4'b0011, fl: 0, grp: 8'hFC, ptr: 2'd0};
        tbl[2] = '{n: 2, m: 4'b0000, s: 8'h00, d: 4'b0011, fl: 2, grp: 8'h33, ptr: 2'd2};
        tbl[3] = '{n: 3, m: 4'b0000, s: 8'h00, d: 4'b0101, fl: 1, grp: 8'h75, ptr: 2'd3};
        tbl[4] = '{n: 4, m: 4'b0010, s: 8'h0C, d: 4'b1011, fl: 0, grp: 8'hFD, ptr: 2'd3};
        tbl[5] = '{n: 1, m: 4'b0001, s: 8'h02, d: 4'b0001, fl: 1, grp: 8'h44, ptr: 2'd0};
        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Stall: full auto group 0,1,0,1 held for 3 cycles with beats offered.
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'hFA);
        finish_group("stall", 2'd0, 3);

        // Flush with an empty mask and no beat is ignored.
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("empty flush out_valid", 32'(out_valid), 32'd0);
        chk("empty flush in_ready", 32'(in_ready), 32'd1);
        chk("empty flush lanes", 32'(get_grp()), 32'd0);

        // Directed overwrite of lane b, then auto beats from ptr=0.
        drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        chk("overwrite group", 32'(get_grp()), 32'h22);
        chk("overwrite out_valid", 32'(out_valid), 32'd0);
        chk("overwrite ptr", 32'(ptr), 32'd0);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("overwrite not yet full", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'hFD);
        finish_group("overwrite", 2'd0, 0);

        // Reset mid-group discards the partial group.
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("midrst pre ptr", 32'(ptr), 32'd2);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("midrst lanes", 32'(get_grp()), 32'd0);
        chk("midrst ptr", 32'(ptr), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'hF9);
        finish_group("midrst", 2'd0, 0);

        // Random auto-mode groups.
        for (int r = 0; r < 4; r++) begin
            rd = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, 1'b0, 2'($urandom_range(0, 3)), rd[k], 1'b0, 1'b0);
            end
            exp_q.push_back({4'hF, rd});
            finish_group($sformatf("rand%0d", r), 2'd0, 0);
        end

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
